poly_wave_synth: RTL and testbench
==================================

Name: poly_wave_synth

Overview:
- Parametrised N-voice wavetable synthesiser. Generalises the fixed 3-voice note decoder to NUM_VOICES voices.
- Uses a fractional phase accumulator per voice and one time-multiplexed wave ROM port shared by all voices.
- Mixes enabled voices with a true divide-by-active-count. The divide is a sequential restoring divider.
- Sits between the note/step lookup logic (upstream) and the audio DAC/PWM stage (downstream). Produces one mixed sample per sample_tick.

Parameters:
NUM_VOICES, 3, number of voices; must be ≥1
ADDR_W, 12, integer phase bits = ROM address bits per waveform
FRAC_W, 8, fractional phase bits
SAMPLE_W, 8, unsigned sample width from ROM and to output
CNT_W, $clog2(NUM_VOICES+1), active-voice count width (derived)
SUM_W, SAMPLE_W+CNT_W, mix accumulator width (derived)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sample_tick  in  1  one-cycle request for a new output sample
voice_en  in  NUM_VOICES  per-voice enable; bit i = voice i
voice_step  in  NUM_VOICES*(ADDR_W+FRAC_W)  per-voice phase increment; voice i at [i*(ADDR_W+FRAC_W) +: ADDR_W+FRAC_W]
voice_wave  in  NUM_VOICES*2  per-voice waveform: 0 sine, 1 triangle, 2 square, 3 saw
rom_addr  out  ADDR_W+2  wave ROM address {wave, phase_int}
rom_data  in  SAMPLE_W  ROM read data; valid exactly 1 cycle after rom_addr
sample_out  out  SAMPLE_W  mixed sample; holds between updates
sample_valid  out  1  one-cycle pulse when sample_out updates
busy  out  1  high whenever state ≠ IDLE
overrun  out  1  sticky; set when sample_tick arrives while busy

Behaviour:
- Reset: asynchronous and active-low. All registers clear immediately.
  - Outputs: sample_out=0, sample_valid=0, busy=0, overrun=0, rom_addr=0.
  - All phases=0; state=IDLE.
  - Reset mid-frame aborts the frame; no sample_valid is produced.
- FSM states: IDLE → FETCH → DRAIN → DIV → DONE → IDLE.
- IDLE: sample_tick=1 → FETCH. Clear slot=0, sum=0, cnt=0.
- FETCH: lasts NUM_VOICES cycles, slot 0..NUM_VOICES-1.
  - rom_addr = {voice_wave[slot], phase[slot][ADDR_W+FRAC_W-1:FRAC_W]}. voice_wave and voice_step are sampled in that slot's cycle.
  - If voice_en[slot]=1: phase[slot] ← phase[slot]+voice_step[slot], mod 2^(ADDR_W+FRAC_W); wraps silently.
  - If voice_en[slot]=0: phase[slot] ← 0, so the voice restarts at phase 0 when re-enabled.
  - The enable bit is pipelined one cycle alongside the read. On the cycle after each fetch, if that bit is set: sum += rom_data, cnt += 1.
- DRAIN: 1 cycle; accumulates the last slot's rom_data.
- DIV: SUM_W cycles, restoring division, quotient = floor(sum/cnt).
  - cnt=0: skip the division result and force quotient=0. DIV still runs its full length so latency stays fixed.
- DONE: 1 cycle. sample_out ← quotient[SAMPLE_W-1:0]; sample_valid=1 this cycle only; return to IDLE.
  - The quotient always fits in SAMPLE_W because sum ≤ cnt·(2^SAMPLE_W−1).
- Latency: sample_valid is high in the cycle NUM_VOICES+SUM_W+2 clocks after the edge that samples sample_tick. Default is 15.
- Throughput: at most one sample per NUM_VOICES+SUM_W+3 cycles.
- sample_tick while busy:
  - The tick is ignored and the frame in flight is unaffected.
  - overrun is set and stays set until reset.
  - A tick in the DONE cycle counts as busy.
- Inputs changing mid-frame: only the values sampled in each voice's FETCH slot apply to that frame.
- rom_addr holds its last value outside FETCH.

Test Plan:
- Reset/defaults: assert rst_n=0 mid-DIV → all outputs 0 immediately. After release with no tick, sample_valid stays 0 for 100 cycles.
- Single voice: voice_en=001, step0=0x00100 (1.0), wave=saw, model ROM data = addr[7:0]. Four ticks spaced 20 cycles apart → sample_out 0,1,2,3. sample_valid exactly 15 cycles after each tick.
- Averaging: three voices enabled with ROM returning 200, 100, 30 → sample_out=110. Disable voice 2 → (200+100)/2=150. voice_en=000 → sample_out=0 with sample_valid still pulsed.
- Fractional step and wrap: step=0x00080 (0.5) → integer address advances every 2nd tick. Start phase near 0xFFF80 with step 0x00100 → address sequence 0xFFF then 0x000.
- Retrigger: enable voice 1, run 5 ticks, disable for one tick, re-enable → first fetch address integer part = 0.
- Overrun: second sample_tick 4 cycles after the first → overrun=1 and stays 1. Only one sample_valid is produced. First sample value is unchanged.

Source files
------------

// File: rtl/poly_wave_synth.sv
// poly_wave_synth
//   N-voice wavetable synthesiser. Each voice owns a fractional phase
//   accumulator; all voices share one wave ROM port, read one voice per
//   cycle. The enabled voices are averaged with a sequential restoring
//   divider, producing one mixed sample per accepted sample_tick.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   sample_tick  one-cycle request for a new output sample
//   voice_en     per-voice enable (bit i = voice i)
//   voice_step   per-voice phase increment, voice i at [i*PH_W +: PH_W]
//   voice_wave   per-voice waveform select (0 sine, 1 tri, 2 square, 3 saw)
//   rom_addr     wave ROM address {wave, phase_int}
//   rom_data     ROM read data, valid one cycle after rom_addr
//   sample_out   mixed sample, holds between updates
//   sample_valid one-cycle pulse when sample_out updates
//   busy         high whenever the FSM is not idle
//   overrun      sticky flag: a tick arrived while busy
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for sample_tick
// S_FETCH | one cycle per voice: issue ROM read, advance phase
// S_DRAIN | accumulate the last voice's ROM data
// S_DIV   | SUM_W restoring-division iterations, sum / cnt
// S_DONE  | load sample_out, pulse sample_valid, back to idle
module poly_wave_synth #(
    parameter int NUM_VOICES = 3,
    parameter int ADDR_W     = 12,
    parameter int FRAC_W     = 8,
    parameter int SAMPLE_W   = 8,
    parameter int CNT_W      = $clog2(NUM_VOICES + 1),
    parameter int SUM_W      = SAMPLE_W + CNT_W
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   sample_tick,
    input  logic [NUM_VOICES-1:0]                  voice_en,
    input  logic [NUM_VOICES*(ADDR_W+FRAC_W)-1:0]  voice_step,
    input  logic [NUM_VOICES*2-1:0]                voice_wave,
    output logic [ADDR_W+1:0]                      rom_addr,
    input  logic [SAMPLE_W-1:0]                    rom_data,
    output logic [SAMPLE_W-1:0]                    sample_out,
    output logic                                   sample_valid,
    output logic                                   busy,
    output logic                                   overrun
);

    localparam int PH_W   = ADDR_W + FRAC_W;
    localparam int SLOT_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int DIV_W  = (SUM_W > 1) ? $clog2(SUM_W) : 1;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_VOICES - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SUM_W - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_DIV   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]          state;
    logic [SLOT_W-1:0]   slot;
    logic [PH_W-1:0]     phase [NUM_VOICES];
    logic                en_d;
    logic [SUM_W-1:0]    sum;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    rem;
    logic [DIV_W-1:0]    div_cnt;
    logic [ADDR_W+1:0]   rom_addr_q;

    logic [ADDR_W-1:0]   cur_int;
    logic [1:0]          cur_wave;
    logic                cur_en;
    logic [ADDR_W+1:0]   fetch_addr;
    logic [SUM_W-1:0]    sum_acc;
    logic [CNT_W:0]      trial;
    logic                take;
    logic [CNT_W-1:0]    diff;

    // Per-slot selection of the voice being fetched this cycle.
    always_comb begin
        cur_int  = '0;
        cur_wave = '0;
        cur_en   = 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (slot == SLOT_W'(i)) begin
                cur_int  = phase[i][PH_W-1:FRAC_W];
                cur_wave = voice_wave[i*2 +: 2];
                cur_en   = voice_en[i];
            end
        end
    end

    assign fetch_addr = {cur_wave, cur_int};
    // The address is driven straight from the phase during FETCH so the ROM
    // data lands one cycle later; outside FETCH the last address is held.
    assign rom_addr   = (state == S_FETCH) ? fetch_addr : rom_addr_q;
    assign busy       = (state != S_IDLE);
    assign sum_acc    = sum + SUM_W'(rom_data);

    // Restoring divider step: the dividend shifts out of sum's MSB into the
    // remainder while quotient bits shift into sum's LSB. Since rem < cnt,
    // the low CNT_W bits of the subtraction are exact whenever take is set.
    assign trial = {rem, sum[SUM_W-1]};
    assign take  = (trial >= {1'b0, cnt});
    assign diff  = trial[CNT_W-1:0] - cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase[i] <= '0;
            end
        end else if (state == S_FETCH) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (slot == SLOT_W'(i)) begin
                    // A disabled voice parks at phase 0 so it restarts cleanly.
                    phase[i] <= voice_en[i] ? phase[i] + voice_step[i*PH_W +: PH_W] : '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            slot         <= '0;
            en_d         <= 1'b0;
            sum          <= '0;
            cnt          <= '0;
            rem          <= '0;
            div_cnt      <= '0;
            rom_addr_q   <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (sample_tick && (state != S_IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (sample_tick) begin
                        state <= S_FETCH;
                        slot  <= '0;
                        sum   <= '0;
                        cnt   <= '0;
                        rem   <= '0;
                        en_d  <= 1'b0;
                    end
                end
                S_FETCH: begin
                    rom_addr_q <= fetch_addr;
                    en_d       <= cur_en;
                    if (en_d) begin
                        sum <= sum_acc;
                        cnt <= cnt + 1'b1;
                    end
                    if (slot == LAST_SLOT) begin
                        state <= S_DRAIN;
                    end else begin
                        slot <= slot + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (en_d) begin
                        sum <= sum_acc;
                        cnt <= cnt + 1'b1;
                    end
                    en_d    <= 1'b0;
                    div_cnt <= DIV_LAST;
                    state   <= S_DIV;
                end
                S_DIV: begin
                    sum <= {sum[SUM_W-2:0], take};
                    rem <= take ? diff : trial[CNT_W-1:0];
                    if (div_cnt == '0) begin
                        state <= S_DONE;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    // With no active voice the divider output is meaningless.
                    sample_out   <= (cnt == '0) ? '0 : sum[SAMPLE_W-1:0];
                    sample_valid <= 1'b1;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_poly_wave_synth.sv
// tb_poly_wave_synth
//   Randomised bench for poly_wave_synth. A frame-level model tracks each
//   voice's phase and computes the expected ROM addresses and mixed sample
//   directly from the averaging rules; a behavioural ROM answers reads.
module tb_poly_wave_synth;

    localparam int NV = 3;
    localparam int AW = 12;
    localparam int FW = 8;
    localparam int SW = 8;
    localparam int PW = AW + FW;
    localparam int LATENCY = 15;

    logic              clk;
    logic              rst_n;
    logic              sample_tick;
    logic [NV-1:0]     voice_en;
    logic [NV*PW-1:0]  voice_step;
    logic [NV*2-1:0]   voice_wave;
    logic [AW+1:0]     rom_addr;
    logic [SW-1:0]     rom_data;
    logic [SW-1:0]     sample_out;
    logic              sample_valid;
    logic              busy;
    logic              overrun;

    int n_tests = 0;
    int n_fail  = 0;
    int rom_mode = 0;
    int mph [NV];
    bit model_ovr = 0;
    int cap_addr [NV];

    poly_wave_synth #(
        .NUM_VOICES(NV), .ADDR_W(AW), .FRAC_W(FW), .SAMPLE_W(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick),
        .voice_en(voice_en), .voice_step(voice_step), .voice_wave(voice_wave),
        .rom_addr(rom_addr), .rom_data(rom_data), .sample_out(sample_out),
        .sample_valid(sample_valid), .busy(busy), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rom_fn(input int mode, input int addr);
        int w;
        w = addr >> AW;
        case (mode)
            0:       return addr & 255;
            1:       return (w == 0) ? 200 : (w == 1) ? 100 : (w == 2) ? 30 : 77;
            default: return ((addr * 73) ^ (addr >> 3)) & 255;
        endcase
    endfunction

    always @(posedge clk) rom_data <= 8'(rom_fn(rom_mode, int'(rom_addr)));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_voice(input int v, input bit en, input int step, input int wave);
        voice_en[v]             = en;
        voice_step[v*PW +: PW]  = PW'(step);
        voice_wave[v*2 +: 2]    = 2'(wave);
    endtask

    task automatic check_reset_outputs();
        check("rst_sample_out", 32'(sample_out), 0);
        check("rst_valid", 32'(sample_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_rom_addr", 32'(rom_addr), 0);
    endtask

    task automatic model_reset();
        for (int v = 0; v < NV; v++) mph[v] = 0;
        model_ovr = 0;
    endtask

    // One frame: model the frame, issue the tick, check fetch addresses,
    // latency, pulse count, value and overrun. ovr_at>0 injects an extra
    // tick sampled ovr_at edges after the accepted one.
    task automatic run_frame(input int ovr_at, output int got);
        int s, c, exp_s, lat, nval, w, st;
        int ea [NV];
        logic [NV-1:0]    sv_en;
        logic [NV*PW-1:0] sv_step;
        logic [NV*2-1:0]  sv_wave;
        s = 0; c = 0; lat = -1; nval = 0; got = 0;
        for (int v = 0; v < NV; v++) begin
            w  = int'(voice_wave[v*2 +: 2]);
            st = int'(voice_step[v*PW +: PW]);
            ea[v] = (w << AW) | (mph[v] >> FW);
            if (voice_en[v]) begin
                s += rom_fn(rom_mode, ea[v]);
                c++;
                mph[v] = (mph[v] + st) % (1 << PW);
            end else begin
                mph[v] = 0;
            end
        end
        exp_s = (c != 0) ? s / c : 0;
        if (ovr_at > 0) model_ovr = 1;
        sv_en = voice_en; sv_step = voice_step; sv_wave = voice_wave;

        @(negedge clk);
        sample_tick = 1'b1;
        @(posedge clk);
        #1 sample_tick = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (k == 0) check("busy", 32'(busy), 1);
            if (k < NV) begin
                cap_addr[k] = int'(rom_addr);
                check($sformatf("addr_slot%0d", k), 32'(rom_addr), 32'(ea[k]));
            end
            if (k == 3) begin
                // Fetch is over; later input changes must not affect this frame.
                voice_en   = NV'($urandom);
                voice_step = (NV*PW)'({$urandom, $urandom});
                voice_wave = (NV*2)'($urandom);
            end
            if (k + 1 == ovr_at) sample_tick = 1'b1;
            @(posedge clk);
            #1 sample_tick = 1'b0;
            if (sample_valid) begin
                nval++;
                if (lat < 0) begin
                    lat = k + 1;
                    got = int'(sample_out);
                end
            end
        end
        voice_en = sv_en; voice_step = sv_step; voice_wave = sv_wave;
        check("latency", 32'(lat), 32'(LATENCY));
        check("valid_count", 32'(nval), 1);
        check("sample", 32'(got), 32'(exp_s));
        check("overrun", 32'(overrun), 32'(model_ovr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int nval;
        rst_n = 1'b0; sample_tick = 1'b0;
        voice_en = '0; voice_step = '0; voice_wave = '0;
        model_reset();
        #2 check_reset_outputs();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Single saw voice, step 1.0, ROM = addr[7:0].
        rom_mode = 0;
        set_voice(0, 1, 'h100, 3);
        for (int i = 0; i < 4; i++) begin
            run_frame(0, g);
            check("saw_seq", 32'(g), 32'(i));
        end

        // Averaging over waves 0,1,2 -> 200,100,30.
        rom_mode = 1;
        set_voice(0, 1, 'h123, 0);
        set_voice(1, 1, 'h456, 1);
        set_voice(2, 1, 'h789, 2);
        run_frame(0, g); check("avg3", 32'(g), 110);
        voice_en[2] = 1'b0;
        run_frame(0, g); check("avg2", 32'(g), 150);
        voice_en = '0;
        run_frame(0, g); check("avg0", 32'(g), 0);

        // Fractional step 0.5.
        rom_mode = 0;
        set_voice(0, 1, 'h80, 3);
        for (int i = 0; i < 5; i++) begin
            run_frame(0, g);
            check("half_step", 32'(g), 32'(i / 2));
        end

        // Phase wrap from 0xFFF80 with step 1.0.
        voice_en = '0;
        run_frame(0, g);
        set_voice(0, 1, 'hFFF80, 3);
        run_frame(0, g);
        voice_step[0 +: PW] = PW'('h100);
        run_frame(0, g);
        check("wrap_addr_hi", 32'(cap_addr[0] & 'hFFF), 'hFFF);
        check("wrap_val_hi", 32'(g), 255);
        run_frame(0, g);
        check("wrap_addr_lo", 32'(cap_addr[0] & 'hFFF), 0);

        // Retrigger of voice 1.
        rom_mode = 2;
        set_voice(0, 0, 0, 0);
        set_voice(2, 0, 0, 0);
        set_voice(1, 1, int'($urandom_range(1, 'hFFFFF)), int'($urandom_range(0, 3)));
        for (int i = 0; i < 5; i++) run_frame(0, g);
        voice_en[1] = 1'b0;
        run_frame(0, g);
        voice_en[1] = 1'b1;
        run_frame(0, g);
        check("retrig_addr", 32'(cap_addr[1] & 'hFFF), 0);

        // Random frames.
        for (int i = 0; i < 30; i++) begin
            voice_en = NV'($urandom);
            for (int v = 0; v < NV; v++) begin
                voice_step[v*PW +: PW] = PW'($urandom);
                voice_wave[v*2 +: 2]   = 2'($urandom);
            end
            run_frame(0, g);
        end

        // Overrun: second tick 4 cycles after the first; stays sticky.
        voice_en = '1;
        run_frame(4, g);
        run_frame(0, g);

        // Reset in the middle of DIV.
        @(negedge clk);
        sample_tick = 1'b1;
        @(posedge clk);
        #1 sample_tick = 1'b0;
        repeat (8) @(posedge clk);
        #3 rst_n = 1'b0;
        model_reset();
        #1 check_reset_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nval = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1 if (sample_valid) nval++;
        end
        check("idle_no_valid", 32'(nval), 0);

        // Function after reset starts from phase 0.
        run_frame(0, g);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
